updn_cmd_ctrl: RTL and testbench

//   Upstream command stage for the 5-bit up/down counter.
//   - Takes raw, bouncy push-button inputs (up, down, load) and synchronises and debounces each one.
//   - Turns press events, plus auto-repeat events while up/down is held, into single-cycle Load/Up/Down

---
 rtl/updn_cmd_ctrl.sv | 137 +++++++++++++
 tb/tb_updn_cmd_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/updn_cmd_ctrl.sv
// updn_cmd_ctrl: push-button front end for the up/down counter.
// Each raw button is synchronised and debounced. Press events and up/down
// auto-repeat events become single-cycle Load/Up/Down commands. High/Low from
// the counter gate off increments and decrements that would go past a limit.
module updn_cmd_ctrl #(
   parameter int WIDTH     = 5,
   parameter int DB_CYCLES = 4,
   parameter int REP_DELAY = 16,
   parameter int REP_RATE  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             btn_up,
   input  logic             btn_dn,
   input  logic             btn_ld,
   input  logic [WIDTH-1:0] ld_val,
   input  logic             High,
   input  logic             Low,
   output logic             Load,
   output logic             Up,
   output logic             Down,
   output logic [WIDTH-1:0] IN
);

   localparam int NB   = 3;   // buttons: bit 0 up, bit 1 down, bit 2 load
   localparam int B_UP = 0;
   localparam int B_DN = 1;
   localparam int B_LD = 2;
   localparam int NR   = 2;   // only up and down auto-repeat

   localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam int HW = $clog2(REP_DELAY + 1);

   localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
   localparam logic [HW-1:0] REP_AT  = HW'(REP_DELAY);
   // Reload to REP_DELAY-REP_RATE counting the repeat cycle itself, so the
   // counter is back at REP_DELAY exactly REP_RATE cycles later.
   localparam logic [HW-1:0] REP_RELOAD = HW'(REP_DELAY - REP_RATE + 1);
   localparam logic [HW-1:0] HOLD_ONE   = HW'(1);

   logic [NB-1:0]         sync1_q, sync1_d;
   logic [NB-1:0]         sync2_q, sync2_d;
   logic [NB-1:0]         stable_q, stable_d;
   logic [NB-1:0]         stable_dly_q, stable_dly_d;
   logic [NB-1:0][CW-1:0] cnt_q, cnt_d;
   logic [NR-1:0][HW-1:0] hold_q, hold_d;
   logic                  load_q, load_d;
   logic                  up_q, up_d;
   logic                  down_q, down_d;
   logic [WIDTH-1:0]      in_q, in_d;

   logic [NB-1:0]         press;
   logic [NR-1:0]         rep;
   logic                  ev_up, ev_dn, ev_ld;

   // Synchroniser, debounce and press-edge detection for every button.
   always_comb begin
      sync1_d      = {btn_ld, btn_dn, btn_up};
      sync2_d      = sync1_q;
      stable_dly_d = stable_q;
      stable_d     = stable_q;
      cnt_d        = '0;
      for (int i = 0; i < NB; i++) begin
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == DB_LAST) begin
               stable_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
      press = stable_q & ~stable_dly_q;
   end

   // Auto-repeat timers: hold_q counts cycles since the press event
   // (0 in the press cycle itself) and is held at zero while released.
   always_comb begin
      hold_d = '0;
      rep    = '0;
      for (int i = 0; i < NR; i++) begin
         if (!stable_q[i]) begin
            hold_d[i] = '0;
         end else if (press[i]) begin
            hold_d[i] = HOLD_ONE;
         end else if (hold_q[i] == REP_AT) begin
            rep[i]    = 1'b1;
            hold_d[i] = REP_RELOAD;
         end else begin
            hold_d[i] = hold_q[i] + HW'(1);
         end
      end
   end

   // Limit suppression, then Load > Down > Up arbitration into the output flops.
   always_comb begin
      ev_ld  = press[B_LD];
      ev_dn  = (press[B_DN] | rep[B_DN]) & ~Low;
      ev_up  = (press[B_UP] | rep[B_UP]) & ~High;
      load_d = ev_ld;
      down_d = ev_dn & ~ev_ld;
      up_d   = ev_up & ~ev_ld & ~ev_dn;
      in_d   = ev_ld ? ld_val : in_q;
   end

   // All state, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         stable_q     <= '0;
         stable_dly_q <= '0;
         cnt_q        <= '0;
         hold_q       <= '0;
         load_q       <= 1'b0;
         up_q         <= 1'b0;
         down_q       <= 1'b0;
         in_q         <= '0;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         stable_q     <= stable_d;
         stable_dly_q <= stable_dly_d;
         cnt_q        <= cnt_d;
         hold_q       <= hold_d;
         load_q       <= load_d;
         up_q         <= up_d;
         down_q       <= down_d;
         in_q         <= in_d;
      end
   end

   assign Load = load_q;
   assign Up   = up_q;
   assign Down = down_q;
   assign IN   = in_q;

endmodule

// File: tb/tb_updn_cmd_ctrl.sv
// tb_updn_cmd_ctrl: directed bench for updn_cmd_ctrl with default parameters.
module tb_updn_cmd_ctrl;

   localparam int WIDTH = 5;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             btn_up = 1'b0;
   logic             btn_dn = 1'b0;
   logic             btn_ld = 1'b0;
   logic [WIDTH-1:0] ld_val = '0;
   logic             High = 1'b0;
   logic             Low = 1'b0;
   logic             Load, Up, Down;
   logic [WIDTH-1:0] IN;

   int n_checks = 0;
   int n_fail   = 0;
   logic [WIDTH-1:0] model_in = '0;

   always #5 clk = ~clk;

   updn_cmd_ctrl #(
      .WIDTH(WIDTH), .DB_CYCLES(4), .REP_DELAY(16), .REP_RATE(4)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .btn_up(btn_up), .btn_dn(btn_dn), .btn_ld(btn_ld),
      .ld_val(ld_val), .High(High), .Low(Low),
      .Load(Load), .Up(Up), .Down(Down), .IN(IN)
   );

   // btn = {ld,dn,up}; exp_pulse = {Load,Down,Up} expected after edge k+6
   typedef struct {
      string            name;
      logic [2:0]       btn;
      logic             high;
      logic             low;
      logic [WIDTH-1:0] val;
      int               len;
      logic [2:0]       exp_pulse;
      logic [WIDTH-1:0] exp_in;
   } vec_t;

   vec_t vecs[12];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check3(input string name, input logic [2:0] exp);
      n_checks++;
      if ({Load, Down, Up} !== exp) begin
         n_fail++;
         $display("FAIL %s: Load/Down/Up got %b expected %b at %0t", name, {Load, Down, Up}, exp, $time);
      end
   endtask

   task automatic check_in(input string name, input logic [WIDTH-1:0] exp);
      n_checks++;
      if (IN !== exp) begin
         n_fail++;
         $display("FAIL %s: IN got %0d expected %0d at %0t", name, IN, exp, $time);
      end
   endtask

   task automatic release_all();
      btn_up = 1'b0;
      btn_dn = 1'b0;
      btn_ld = 1'b0;
   endtask

   task automatic settle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic run_vec(input vec_t v);
      High   = v.high;
      Low    = v.low;
      ld_val = v.val;
      {btn_ld, btn_dn, btn_up} = v.btn;
      for (int j = 1; j <= 14; j++) begin
         tick();
         check3(v.name, (j == 7) ? v.exp_pulse : 3'b000);
         check_in({v.name, "_in"}, (j < 7) ? model_in : v.exp_in);
         if (j == v.len) release_all();
      end
      model_in = v.exp_in;
      High = 1'b0;
      Low  = 1'b0;
      settle(12);
   endtask

   initial begin
      int up_count;

      //            name          btn     H     L     val    len exp     in
      vecs[0]  = '{"up_press",   3'b001, 1'b0, 1'b0, 5'd0,  10, 3'b001, 5'd0};
      vecs[1]  = '{"up_glitch3", 3'b001, 1'b0, 1'b0, 5'd0,  3,  3'b000, 5'd0};
      vecs[2]  = '{"dn_press",   3'b010, 1'b0, 1'b0, 5'd0,  10, 3'b010, 5'd0};
      vecs[3]  = '{"ld_press",   3'b100, 1'b0, 1'b0, 5'd7,  10, 3'b100, 5'd7};
      vecs[4]  = '{"up_at_high", 3'b001, 1'b1, 1'b0, 5'd0,  10, 3'b000, 5'd7};
      vecs[5]  = '{"dn_at_low",  3'b010, 1'b0, 1'b1, 5'd0,  10, 3'b000, 5'd7};
      vecs[6]  = '{"ld_and_up",  3'b101, 1'b0, 1'b0, 5'd19, 10, 3'b100, 5'd19};
      vecs[7]  = '{"up_and_dn",  3'b011, 1'b0, 1'b0, 5'd3,  10, 3'b010, 5'd19};
      vecs[8]  = '{"dn_at_high", 3'b010, 1'b1, 1'b0, 5'd0,  10, 3'b010, 5'd19};
      vecs[9]  = '{"up_at_low",  3'b001, 1'b0, 1'b1, 5'd0,  10, 3'b001, 5'd19};
      vecs[10] = '{"ld_at_lims", 3'b100, 1'b1, 1'b1, 5'd31, 10, 3'b100, 5'd31};
      vecs[11] = '{"up_len4",    3'b001, 1'b0, 1'b0, 5'd0,  4,  3'b001, 5'd31};

      // reset state
      settle(3);
      check3("reset_out", 3'b000);
      check_in("reset_in", '0);
      rst_n = 1'b1;
      settle(4);

      for (int v = 0; v < 12; v++) run_vec(vecs[v]);

      // auto-repeat: press pulse, then +16, +20, ... +40
      up_count = 0;
      btn_up = 1'b1;
      for (int j = 1; j <= 7; j++) begin
         tick();
         check3("rep_press", (j == 7) ? 3'b001 : 3'b000);
         if (Up === 1'b1) up_count++;
      end
      for (int n = 1; n <= 40; n++) begin
         tick();
         check3("rep_hold", (n >= 16 && ((n - 16) % 4) == 0) ? 3'b001 : 3'b000);
         if (Up === 1'b1) up_count++;
      end
      n_checks++;
      if (up_count != 8) begin
         n_fail++;
         $display("FAIL rep_count: got %0d Up pulses expected 8", up_count);
      end
      release_all();
      settle(30);

      // High blocks the press, repeat goes through once High drops
      High = 1'b1;
      btn_up = 1'b1;
      for (int j = 1; j <= 7; j++) begin
         tick();
         check3("high_press", 3'b000);
      end
      for (int n = 1; n <= 16; n++) begin
         tick();
         check3("high_release_rep", (n == 16) ? 3'b001 : 3'b000);
         if (n == 10) High = 1'b0;
      end
      release_all();
      settle(30);

      // reset in the middle of a down repeat
      btn_dn = 1'b1;
      for (int j = 1; j <= 7; j++) begin
         tick();
         check3("rst_seq_press", (j == 7) ? 3'b010 : 3'b000);
      end
      for (int n = 1; n <= 16; n++) begin
         tick();
         check3("rst_seq_rep", (n == 16) ? 3'b010 : 3'b000);
      end
      check_in("rst_seq_in_before", model_in);
      rst_n = 1'b0;
      #1;
      check3("rst_async_out", 3'b000);
      check_in("rst_async_in", '0);
      model_in = '0;
      tick();
      tick();
      check3("rst_held_out", 3'b000);
      rst_n = 1'b1;
      for (int j = 1; j <= 12; j++) begin
         tick();
         check3("post_rst_press", (j == 7) ? 3'b010 : 3'b000);
         check_in("post_rst_in", model_in);
      end
      release_all();
      settle(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
